mem_bus_arbiter: RTL

Sequences the single shared memory/IO port between the instruction-fetch requester and the load/store requester. It owns the port's en / RW / MemIO / address / write-data lines, runs one access at a time through a fixed-latency protocol, and returns read data with a one-cycle ack pulse. It sits between the fetch and execute stages and the CPU memory/IO export block.

---
 rtl/cpu_bus_pkg.sv | 10 +
 rtl/rr_arbiter2.sv | 17 +
 rtl/mem_bus_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared bus FSM states, owner encoding and port field constants
// Used by mem_bus_arbiter, the fetch/execute stages and the memory/IO export block.
package cpu_bus_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} bus_state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;
  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;
  localparam logic MEMIO_MEM = 1'b0;
  localparam logic MEMIO_IO  = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick between fetch (a) and load/store (b)
// Ports: i_req_a/i_req_b requests, i_last_owner last served owner,
//        o_grant any request present, o_owner chosen owner.
module rr_arbiter2
  import cpu_bus_pkg::*;
(
  input  logic   i_req_a,
  input  logic   i_req_b,
  input  owner_t i_last_owner,
  output logic   o_grant,
  output owner_t o_owner
);
  assign o_grant = i_req_a | i_req_b;
  // On a tie the side not served last wins, so neither requester starves.
  assign o_owner = (i_req_a & i_req_b) ? ((i_last_owner == OWN_LS) ? OWN_IF : OWN_LS)
                                       : (i_req_b ? OWN_LS : OWN_IF);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: sequences the shared memory/IO port between fetch and load/store
// Ports: clk/rst_n (async active-low); if_req/if_addr -> if_ack/if_rdata fetch side;
//        ls_req/ls_we/ls_io/ls_addr/ls_wdata -> ls_ack/ls_rdata load/store side;
//        mem_en/mem_rw/mem_memio/mem_addr/mem_wdata/mem_rdata shared port; bus_busy.
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic        ls_io,
  input  logic [15:0] ls_addr,
  input  logic [15:0] ls_wdata,
  output logic        ls_ack,
  output logic [15:0] ls_rdata,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        mem_memio,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        bus_busy
);
  // WAIT lasts MEM_LAT-1 cycles, so the counter starts at MEM_LAT-2 and exits at zero.
  localparam logic [1:0] LAT_CNT = 2'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);
  bus_state_t r_state, w_next;
  owner_t     r_owner, r_last_owner, w_pick;
  logic       w_grant, w_capture;
  logic [1:0] r_cnt;
  rr_arbiter2 u_rr (
    .i_req_a      (if_req),
    .i_req_b      (ls_req),
    .i_last_owner (r_last_owner),
    .o_grant      (w_grant),
    .o_owner      (w_pick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // w_capture marks the cycle whose closing edge samples mem_rdata.
  always_comb begin
    w_next = r_state;
    w_capture = 1'b0;
    case (r_state)
      IDLE:  if (w_grant) w_next = ISSUE;
      ISSUE: begin
        w_next = (MEM_LAT > 1) ? WAIT : DONE;
        w_capture = (MEM_LAT == 1);
      end
      WAIT:  if (r_cnt == '0) begin
        w_next = DONE;
        w_capture = 1'b1;
      end
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  assign mem_en   = r_state == ISSUE;
  assign bus_busy = r_state != IDLE;
  assign if_ack   = r_state == DONE && r_owner == OWN_IF;
  assign ls_ack   = r_state == DONE && r_owner == OWN_LS;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_owner      <= OWN_IF;
      r_last_owner <= OWN_LS;
      r_cnt        <= '0;
      mem_rw       <= RW_READ;
      mem_memio    <= MEMIO_MEM;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rdata     <= '0;
      ls_rdata     <= '0;
    end else begin
      if (r_state == IDLE && w_grant) begin
        r_owner   <= w_pick;
        mem_rw    <= (w_pick == OWN_LS) ? ls_we : RW_READ;
        mem_memio <= (w_pick == OWN_LS) ? ls_io : MEMIO_MEM;
        mem_addr  <= (w_pick == OWN_LS) ? ls_addr : if_addr;
        mem_wdata <= (w_pick == OWN_LS) ? ls_wdata : '0;
      end
      if (r_state == ISSUE) r_cnt <= LAT_CNT;
      else if (r_state == WAIT && r_cnt != '0) r_cnt <= r_cnt - 2'd1;
      if (w_capture && r_owner == OWN_IF) if_rdata <= mem_rdata;
      if (w_capture && r_owner == OWN_LS && mem_rw == RW_READ) ls_rdata <= mem_rdata;
      if (r_state == DONE) r_last_owner <= r_owner;
    end
endmodule
